ws2812_stream: RTL and testbench

Streaming WS2812-family LED strip driver: the successor to the single-word WS2812B driver in the `ledstrip` peripheral. It is parametrised for pixel width, clock rate, bit timing and input buffering. Pixels are pushed through a small FIFO, so the CPU can queue ahead. Pixels are sent back-to-back with no inter-pixel gap, and a latch (reset) pulse is issued after any pixel tagged `latch_in`. The block sits between the TinyQV peripheral register interface and the strip data pin.

---
 rtl/ledstrip_pkg.sv | 23 ++
 rtl/ws2812_stream_if.sv | 10 +
 rtl/ledstrip_fifo.sv | 59 +++++
 rtl/ws2812_stream.sv | 187 ++++++++++++++++++
 tb/tb_ws2812_stream.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ledstrip_pkg.sv
// rtl/ledstrip_pkg.sv - shared FSM encoding, counter width and elaboration helpers for ws2812_stream
package ledstrip_pkg;

    localparam int CNT_W = 20;

    typedef enum logic [1:0] {
        POR_WAIT = 2'd0,
        IDLE     = 2'd1,
        SEND     = 2'd2,
        LATCH    = 2'd3
    } led_state_t;

    // Truncating conversion; evaluated at elaboration only.
    function automatic int ns_to_cycles(input int clock_mhz, input int ns);
        return (clock_mhz * ns) / 1000;
    endfunction

    // FIFO entry is {latch, pixel}.
    function automatic int entry_width(input int bits_per_led);
        return bits_per_led + 1;
    endfunction

endpackage

// File: rtl/ws2812_stream_if.sv
// rtl/ws2812_stream_if.sv - pixel write handshake between the register block and ws2812_stream
interface ws2812_stream_if;
    logic [31:0] data_in;
    logic        latch_in;
    logic        valid;
    logic        ready;

    modport master (output data_in, output latch_in, output valid, input ready);
    modport slave  (input data_in, input latch_in, input valid, output ready);
endinterface

// File: rtl/ledstrip_fifo.sv
// rtl/ledstrip_fifo.sv - synchronous first-word-fall-through FIFO with occupancy count
module ledstrip_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ws2812_stream.sv
// rtl/ws2812_stream.sv - streaming WS2812 strip driver; LEDSTRIP_UNDERRUN_EN adds the sticky underrun flag
module ws2812_stream
    import ledstrip_pkg::*;
#(
    parameter int CLOCK_MHZ    = 64,
    parameter int BITS_PER_LED = 24,
    parameter int FIFO_DEPTH   = 4,
    parameter int T0H_NS       = 400,
    parameter int T1H_NS       = 800,
    parameter int PERIOD_NS    = 1250,
    parameter int RES_NS       = 300000
) (
    input  logic                            clk,
    input  logic                            rst,
    ws2812_stream_if.slave                  bus,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
    output logic                            busy,
`ifdef LEDSTRIP_UNDERRUN_EN
    input  logic                            clear_underrun,
    output logic                            underrun,
`endif
    output logic                            led
);

    localparam int T0H_I    = ns_to_cycles(CLOCK_MHZ, T0H_NS);
    localparam int T1H_I    = ns_to_cycles(CLOCK_MHZ, T1H_NS);
    localparam int PERIOD_I = ns_to_cycles(CLOCK_MHZ, PERIOD_NS);
    localparam int RES_I    = ns_to_cycles(CLOCK_MHZ, RES_NS);
    localparam int EW       = entry_width(BITS_PER_LED);
    localparam int BIT_W    = $clog2(BITS_PER_LED);

    localparam logic [CNT_W-1:0] T0H_C       = CNT_W'(T0H_I);
    localparam logic [CNT_W-1:0] T1H_C       = CNT_W'(T1H_I);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_I - 1);
    localparam logic [CNT_W-1:0] RES_LAST    = CNT_W'(RES_I - 1);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(BITS_PER_LED - 1);

    if (RES_I >= (1 << CNT_W)) begin : g_bad_res
        $error("ws2812_stream: latch time does not fit the timing counter");
    end
    if (T1H_I >= PERIOD_I) begin : g_bad_t1h
        $error("ws2812_stream: T1H must be shorter than the bit period");
    end
    if (BITS_PER_LED != 24 && BITS_PER_LED != 32) begin : g_bad_bits
        $error("ws2812_stream: BITS_PER_LED must be 24 or 32");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ws2812_stream: FIFO_DEPTH must be a power of two in 2..16");
    end

    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          unused_data;

    assign bus.ready   = !full;
    assign push        = bus.valid && bus.ready;
    assign wdata       = {bus.latch_in, bus.data_in[BITS_PER_LED-1:0]};
    assign unused_data = ^bus.data_in;

    ledstrip_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    led_state_t              state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [BIT_W-1:0]        bit_idx, bit_nxt;
    logic [BITS_PER_LED-1:0] shreg, sh_nxt;
    logic                    latch_flag, lf_nxt;
    logic                    led_nxt;
    logic [CNT_W-1:0]        txh;
    logic [CNT_W-1:0]        cnt_inc;

    assign txh     = shreg[BITS_PER_LED-1] ? T1H_C : T0H_C;
    assign cnt_inc = cnt + CNT_W'(1);

    // The power-up wait is not pending work, so only SEND/LATCH or queued pixels count.
    assign busy = (state == SEND) || (state == LATCH) || !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= POR_WAIT;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            latch_flag <= 1'b0;
            led        <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_nxt;
            shreg      <= sh_nxt;
            latch_flag <= lf_nxt;
            led        <= led_nxt;
        end
    end

    // led is registered, so led_nxt is the level for the counter value being loaded.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        sh_nxt    = shreg;
        lf_nxt    = latch_flag;
        led_nxt   = 1'b0;
        pop       = 1'b0;
        case (state)
            POR_WAIT, LATCH: begin
                if (cnt == RES_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    sh_nxt    = rdata[BITS_PER_LED-1:0];
                    lf_nxt    = rdata[BITS_PER_LED];
                    bit_nxt   = '0;
                    cnt_nxt   = '0;
                    led_nxt   = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (cnt != PERIOD_LAST) begin
                    cnt_nxt = cnt_inc;
                    led_nxt = (cnt_inc < txh);
                end else if (bit_idx != LAST_BIT) begin
                    sh_nxt  = {shreg[BITS_PER_LED-2:0], 1'b0};
                    bit_nxt = bit_idx + BIT_W'(1);
                    cnt_nxt = '0;
                    led_nxt = 1'b1;
                end else if (latch_flag) begin
                    state_nxt = LATCH;
                    cnt_nxt   = '0;
                end else if (!empty) begin
                    pop     = 1'b1;
                    sh_nxt  = rdata[BITS_PER_LED-1:0];
                    lf_nxt  = rdata[BITS_PER_LED];
                    bit_nxt = '0;
                    cnt_nxt = '0;
                    led_nxt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = POR_WAIT;
        endcase
    end

`ifdef LEDSTRIP_UNDERRUN_EN
    logic underrun_set;

    // An unlatched pixel ending with nothing queued means the CPU fell behind.
    assign underrun_set = (state == SEND) && (cnt == PERIOD_LAST) && (bit_idx == LAST_BIT)
                          && !latch_flag && empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (underrun_set) begin
            underrun <= 1'b1;
        end else if (clear_underrun) begin
            underrun <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ws2812_stream.sv
// tb/tb_ws2812_stream.sv - directed self-checking bench for ws2812_stream (24- and 32-bit instances)
module tb_ws2812_stream;

    logic       clk;
    logic       rst;
    logic       rst32;
    logic [2:0] level24;
    logic [2:0] level32;
    logic       busy24;
    logic       busy32;
    logic       led24;
    logic       led32;
`ifdef LEDSTRIP_UNDERRUN_EN
    logic       clr24;
    logic       clr32;
    logic       und24;
    logic       und32;
`endif

    int total = 0;
    int bad   = 0;

    ws2812_stream_if bus24 ();
    ws2812_stream_if bus32 ();

    ws2812_stream dut24 (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus24),
        .level          (level24),
        .busy           (busy24),
`ifdef LEDSTRIP_UNDERRUN_EN
        .clear_underrun (clr24),
        .underrun       (und24),
`endif
        .led            (led24)
    );

    ws2812_stream #(.BITS_PER_LED(32)) dut32 (
        .clk            (clk),
        .rst            (rst32),
        .bus            (bus32),
        .level          (level32),
        .busy           (busy32),
`ifdef LEDSTRIP_UNDERRUN_EN
        .clear_underrun (clr32),
        .underrun       (und32),
`endif
        .led            (led32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered on the negedge where the first bit's counter is 0; leaves on the
    // negedge right after the pixel's last period has elapsed.
    task automatic send_check(input logic [31:0] px, input int nbits, input bit sel, output int errs);
        errs = 0;
        for (int b = nbits - 1; b >= 0; b--) begin
            int txh;
            txh = px[b] ? 51 : 25;
            for (int c = 0; c < 80; c++) begin
                logic v;
                v = sel ? led32 : led24;
                if (v !== (c < txh)) errs++;
                tick();
            end
        end
    endtask

    logic [31:0] px [5];
    int errs;
    int hi_cnt;

    initial begin
        px[0] = 32'h00FF_0000;
        px[1] = 32'h0000_FF00;
        px[2] = 32'h0000_00FF;
        px[3] = 32'h0012_3456;
        px[4] = 32'h00DE_ADBE;

        rst   = 1'b1;
        rst32 = 1'b1;
        bus24.valid = 1'b0; bus24.data_in = '0; bus24.latch_in = 1'b0;
        bus32.valid = 1'b0; bus32.data_in = '0; bus32.latch_in = 1'b0;
`ifdef LEDSTRIP_UNDERRUN_EN
        clr24 = 1'b0;
        clr32 = 1'b0;
`endif
        tick();
        tick();
        chk("rst_led",   32'(led24),   0);
        chk("rst_ready", 32'(bus24.ready), 1);
        chk("rst_level", 32'(level24), 0);
        chk("rst_busy",  32'(busy24),  0);
        chk("rst_level32", 32'(level32), 0);
`ifdef LEDSTRIP_UNDERRUN_EN
        chk("rst_underrun", 32'(und24), 0);
`endif

        bus24.valid   = 1'b1;
        bus24.data_in = 32'h0011_1111;
        tick();
        chk("rst_write_drop", 32'(level24), 0);

        // Release reset and hold valid through the power-up wait: 4 fit, the 5th is refused.
        rst   = 1'b0;
        rst32 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus24.data_in  = px[i];
            bus24.latch_in = (i == 3);
            chk($sformatf("fill_ready%0d", i), 32'(bus24.ready), (i < 4) ? 1 : 0);
            tick();
            chk($sformatf("fill_level%0d", i), 32'(level24), (i < 4) ? i + 1 : 4);
        end
        bus24.valid    = 1'b0;
        bus24.latch_in = 1'b0;

        hi_cnt = 0;
        for (int k = 0; k < 19195; k++) begin
            if (led24 !== 1'b0) hi_cnt++;
            tick();
        end
        if (led24 !== 1'b0) hi_cnt++;
        chk("por_low", hi_cnt, 0);
        chk("por_end_ready", 32'(bus24.ready), 0);
        tick();
        chk("first_rise", 32'(led24), 1);
        chk("first_pop_level", 32'(level24), 3);
        chk("first_pop_ready", 32'(bus24.ready), 1);

        for (int i = 0; i < 4; i++) begin
            send_check(px[i], 24, 1'b0, errs);
            chk($sformatf("stream_px%0d", i), errs, 0);
            chk($sformatf("stream_level%0d", i), 32'(level24), (i < 3) ? 2 - i : 0);
        end
        chk("latch_busy", 32'(busy24), 1);
        hi_cnt = 0;
        for (int k = 0; k < 19200; k++) begin
            if (led24 !== 1'b0) hi_cnt++;
            tick();
        end
        chk("stream_latch_low", hi_cnt, 0);
        chk("stream_idle_busy", 32'(busy24), 0);
        chk("stream_idle_level", 32'(level24), 0);
`ifdef LEDSTRIP_UNDERRUN_EN
        chk("stream_no_underrun", 32'(und24), 0);
`endif

        bus24.valid    = 1'b1;
        bus24.data_in  = 32'h00AA_5500;
        bus24.latch_in = 1'b1;
        tick();
        bus24.valid    = 1'b0;
        bus24.latch_in = 1'b0;
        chk("single_level", 32'(level24), 1);
        chk("single_led_n", 32'(led24), 0);
        tick();
        chk("single_led_n1", 32'(led24), 1);
        chk("single_busy", 32'(busy24), 1);
        send_check(32'h00AA_5500, 24, 1'b0, errs);
        chk("single_px", errs, 0);
        hi_cnt = 0;
        for (int k = 0; k < 19200; k++) begin
            if (led24 !== 1'b0) hi_cnt++;
            tick();
        end
        chk("single_latch_low", hi_cnt, 0);
        chk("single_idle_busy", 32'(busy24), 0);

`ifdef LEDSTRIP_UNDERRUN_EN
        bus24.valid   = 1'b1;
        bus24.data_in = 32'h0000_00FF;
        tick();
        bus24.valid = 1'b0;
        tick();
        chk("und_before", 32'(und24), 0);
        send_check(32'h0000_00FF, 24, 1'b0, errs);
        chk("und_px", errs, 0);
        chk("und_set", 32'(und24), 1);
        clr24 = 1'b1;
        tick();
        clr24 = 1'b0;
        chk("und_clear", 32'(und24), 0);
        bus24.valid = 1'b1;
        tick();
        bus24.valid = 1'b0;
        clr24 = 1'b1;
        tick();
        send_check(32'h0000_00FF, 24, 1'b0, errs);
        clr24 = 1'b0;
        chk("und_set_wins", 32'(und24), 1);
`endif

        // 32-bit instance: second push coincides with the first pop.
        bus32.valid   = 1'b1;
        bus32.data_in = 32'h0000_00FF;
        tick();
        bus32.data_in = 32'hFFFF_FFFF;
        tick();
        bus32.valid = 1'b0;
        chk("w32_push_pop_level", 32'(level32), 1);
        chk("w32_rise", 32'(led32), 1);
        send_check(32'h0000_00FF, 32, 1'b1, errs);
        chk("w32_px", errs, 0);
        chk("w32_level_after", 32'(level32), 0);
        errs = 0;
        for (int c = 0; c < 810; c++) begin
            if (led32 !== ((c % 80) < 51)) errs++;
            bus32.valid   = (c == 0);
            bus32.data_in = 32'h0;
            tick();
        end
        bus32.valid = 1'b0;
        chk("w32_ones_px", errs, 0);
        chk("w32_bit10_led", 32'(led32), 1);
        chk("w32_bit10_level", 32'(level32), 1);
        #1;
        rst32 = 1'b1;
        #1;
        chk("w32_rst_led", 32'(led32), 0);
        chk("w32_rst_level", 32'(level32), 0);
        chk("w32_rst_ready", 32'(bus32.ready), 1);
        tick();
        rst32 = 1'b0;
        tick();
        chk("w32_post_rst_led", 32'(led32), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
